// File: rtl/interp_fixed_divider.sv
// Sequential signed fixed-point divider for the interpolation ratio.
// Restoring, one quotient bit per cycle, saturating on overflow and divide-by-zero.
module interp_fixed_divider #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int NW = WIDTH + FRAC;
    localparam int CW = $clog2(NW + 1);
    localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             dz_q, dz_d;
    logic [NW-1:0]    num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [NW-1:0]    q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             dzo_q, dzo_d;

    logic [WIDTH-1:0] abs_dvd, abs_dvs;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic             pos_ovf, neg_ovf;

    // Magnitudes are unsigned W-bit, so |-2^(W-1)| = 2^(W-1) without wrap.
    assign abs_dvd = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign abs_dvs = divisor[WIDTH-1] ? (~divisor + 1'b1) : divisor;
    assign rem_sh  = {rem_q, num_q[NW-1]};
    assign ge      = rem_sh >= {1'b0, den_q};
    assign pos_ovf = (q_q >> (WIDTH-1)) != '0;
    assign neg_ovf = ((q_q >> WIDTH) != '0) ||
                     (q_q[WIDTH-1] && (q_q[WIDTH-2:0] != '0));

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dz_d    = dz_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        done_d  = done_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        dzo_d   = dzo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d = dividend[WIDTH-1];
                    num_d  = NW'(abs_dvd) << FRAC;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = FIX;
                    end else begin
                        sign_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        dz_d    = 1'b0;
                        den_d   = abs_dvs;
                        rem_d   = '0;
                        q_d     = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        dzo_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = ge ? WIDTH'(rem_sh - {1'b0, den_q}) : rem_sh[WIDTH-1:0];
                q_d   = {q_q[NW-2:0], ge};
                num_d = num_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NW - 1)) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    quo_d = (num_q == '0) ? '0 : (sign_q ? MINN : MAXP);
                    ovf_d = 1'b1;
                    dzo_d = 1'b1;
                end else if (sign_q) begin
                    quo_d = neg_ovf ? MINN : (~q_q[WIDTH-1:0] + 1'b1);
                    ovf_d = neg_ovf;
                end else begin
                    quo_d = pos_ovf ? MAXP : q_q[WIDTH-1:0];
                    ovf_d = pos_ovf;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dz_q    <= 1'b0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            dz_q    <= dz_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            dzo_q   <= dzo_d;
        end
    end

    assign quotient    = quo_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dzo_q;

endmodule
